// File: rtl/pcm_stream_source.sv
// pcm_stream_source
// Streams signed mono PCM samples from a block ROM (1-cycle read latency)
// through a small prefetch FIFO and presents each sample as a stereo pair
// (left with o_ws=1, then right with o_ws=0) on a valid/ready interface,
// with optional arithmetic volume attenuation. Supports end-of-clip stop or
// loop, pause/resume, and play/done status for amplifier shutdown control.

module pcm_stream_source #(
    parameter int W     = 16,
    parameter int L     = 50000,
    parameter int DEPTH = 4,
    localparam int AW   = (L > 1) ? $clog2(L) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          loop,
    input  logic [2:0]    vol_shift,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_rd_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [W-1:0]  o_data,
    output logic          o_ws,
    output logic          playing,
    output logic          done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic           enable_d_r;
    logic           inflight_r;
    logic [W-1:0]   fifo_mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    logic           credit_s;
    logic           issue_s;
    logic           clip_end_s;
    logic           push_s;
    logic           pop_s;
    logic           present_s;
    logic           restart_s;
    logic [AW-1:0]  addr_next_s;

    // Fetch credit, handshake events and restart detection.
    always_comb begin
        credit_s   = (count_r + CW'(inflight_r)) < CW'(DEPTH);
        issue_s    = (state_r == ST_PLAY) && enable && credit_s;
        clip_end_s = issue_s && (rom_addr == AW'(L - 1));
        push_s     = inflight_r;
        // A sample leaves the FIFO only once its right channel has gone out.
        pop_s      = o_valid && o_ready && !o_ws;
        // New pairs start only from an idle bus, with data and while enabled.
        present_s  = !o_valid && enable && (count_r != {CW{1'b0}});
        restart_s  = (state_r == ST_DONE) && enable && !enable_d_r;
    end

    // Next-state logic for the clip playback FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (clip_end_s && !loop) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_DRAIN: begin
                // Finished once nothing is buffered, nothing is in flight
                // and the final right sample has left the bus.
                if ((count_r == {CW{1'b0}}) && !inflight_r && !o_valid) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (restart_s) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next ROM address: advance per issued read, wrap or hold at clip end.
    always_comb begin
        addr_next_s = rom_addr;
        if (restart_s) begin
            addr_next_s = {AW{1'b0}};
        end else if (clip_end_s) begin
            if (loop) begin
                addr_next_s = {AW{1'b0}};
            end else begin
                addr_next_s = rom_addr;
            end
        end else if (issue_s) begin
            addr_next_s = rom_addr + AW'(1);
        end else begin
            addr_next_s = rom_addr;
        end
    end

    // FSM state register and enable edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            enable_d_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            enable_d_r <= enable;
        end
    end

    // ROM address register and read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= {AW{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            rom_addr   <= addr_next_s;
            inflight_r <= issue_s;
        end
    end

    // Prefetch FIFO storage written with the ROM data of last cycle's read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rom_rd_data;
        end
    end

    // Prefetch FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output pair sequencer: left then right, data held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_ws    <= 1'b1;
            o_data  <= {W{1'b0}};
        end else if (present_s) begin
            // Volume is captured here and reused unchanged for the right sample.
            o_valid <= 1'b1;
            o_ws    <= 1'b1;
            o_data  <= $signed(fifo_mem_r[rd_ptr_r]) >>> vol_shift;
        end else if (o_valid && o_ready) begin
            if (o_ws) begin
                o_ws <= 1'b0;
            end else begin
                o_valid <= 1'b0;
                o_ws    <= 1'b1;
            end
        end
    end

    // Registered play/done status derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            playing <= 1'b0;
            done    <= 1'b0;
        end else begin
            playing <= (state_next_s == ST_PLAY) || (state_next_s == ST_DRAIN);
            done    <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pcm_stream_source.sv
// Testbench for pcm_stream_source: directed steps with randomized ready,
// ROM contents and volume, checked against a sample-stream reference model.

module tb_pcm_stream_source;

    localparam int W     = 16;
    localparam int L     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          loop;
    logic [2:0]    vol_shift;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_rd_data;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic          o_ws;
    logic          playing;
    logic          done;

    logic [W-1:0]  rom [L];

    int       n_checks = 0;
    int       n_fail   = 0;
    int       exp_idx;
    bit       exp_ws;
    int       pair_vol;
    bit       loop_mode;
    bit       vol_rand;
    int       n_xfer;
    bit       stall_prev;
    logic [W-1:0] prev_data;
    logic     prev_ws;
    int       prev_addr;
    int       base_xfer;
    int       saved_addr;

    pcm_stream_source #(.W(W), .L(L), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .loop       (loop),
        .vol_shift  (vol_shift),
        .rom_addr   (rom_addr),
        .rom_rd_data(rom_rd_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_ws       (o_ws),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Block ROM with one cycle of read latency.
    always @(posedge clk) rom_rd_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Attenuated sample: floor division by 2**vol on the signed value.
    function automatic logic [W-1:0] model(input int idx, input int vol);
        int sv, d, q;
        logic signed [W-1:0] s;
        s  = rom[idx];
        sv = s;
        d  = 1 << vol;
        if (sv >= 0) q = sv / d;
        else         q = -((-sv + d - 1) / d);
        return q[W-1:0];
    endfunction

    // One clock cycle: drive ready, check stall stability, address and transfers.
    task automatic tick(input int pct);
        bit rdy;
        rdy = ($urandom_range(99) < pct);
        o_ready = rdy;
        if (stall_prev) begin
            check("hold_valid", o_valid, 1);
            check("hold_data", o_data, prev_data);
            check("hold_ws", o_ws, prev_ws);
        end
        if (int'(rom_addr) != prev_addr) begin
            check("addr_step", rom_addr, (prev_addr + 1) % L);
            prev_addr = int'(rom_addr);
        end
        if (o_valid === 1'b1 && rdy) begin
            n_xfer++;
            if (exp_idx >= L) begin
                check("extra_xfer", o_valid & rdy, 0);
            end else begin
                check("xfer_ws", o_ws, exp_ws);
                if (exp_ws) begin
                    pair_vol = vol_shift;
                    if (vol_rand && $urandom_range(2) == 0) vol_shift = 3'($urandom_range(7));
                end
                check("xfer_data", o_data, model(exp_idx, pair_vol));
                if (!exp_ws) begin
                    exp_idx++;
                    if (loop_mode && exp_idx == L) exp_idx = 0;
                end
                exp_ws = !exp_ws;
            end
        end
        stall_prev = (o_valid === 1'b1) && !rdy;
        prev_data  = o_data;
        prev_ws    = o_ws;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        o_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ws", o_ws, 1);
        check("rst_data", o_data, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        exp_idx = 0; exp_ws = 1'b1; n_xfer = 0; stall_prev = 1'b0; prev_addr = 0;
    endtask

    task automatic run_xfer(input int target, input int budget, input int pct);
        int c;
        c = 0;
        while (n_xfer < target && c < budget) begin tick(pct); c++; end
        check("xfer_reached", n_xfer, target);
    endtask

    task automatic run_done(input int budget, input int pct);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin tick(pct); c++; end
        check("done_reached", done, 1);
    endtask

    initial begin
        enable = 1'b0; loop = 1'b0; vol_shift = 3'd0; o_ready = 1'b0; rst = 1'b1;
        vol_rand = 1'b0; loop_mode = 1'b0; pair_vol = 0;
        for (int i = 0; i < L; i++) rom[i] = 16'(i + 1);
        do_reset();

        // Straight playback 1,1,2,2,...,8,8 then done.
        enable = 1'b1;
        run_xfer(1, 50, 100);
        check("t1_playing", playing, 1);
        check("t1_not_done", done, 0);
        run_done(200, 100);
        check("t1_count", n_xfer, 2 * L);
        check("t1_playing_end", playing, 0);
        check("t1_valid_end", o_valid, 0);
        repeat (5) tick(100);
        check("t1_done_held", done, 1);

        // Restart on enable rising edge.
        exp_idx = 0; exp_ws = 1'b1; n_xfer = 0;
        enable = 1'b0; tick(100);
        enable = 1'b1; tick(100); tick(100);
        check("restart_done", done, 0);
        check("restart_playing", playing, 1);
        run_done(200, 100);
        check("restart_count", n_xfer, 2 * L);

        // Stall mid-pair for 5 cycles; fetch halts once FIFO credit is used.
        do_reset();
        enable = 1'b1;
        run_xfer(3, 50, 100);
        repeat (5) tick(0);
        check("stall_valid", o_valid, 1);
        check("stall_addr", rom_addr, exp_idx + DEPTH);
        run_done(200, 100);
        check("stall_count", n_xfer, 2 * L);

        // Looping with random data, ready and volume.
        for (int i = 0; i < L; i++) rom[i] = 16'($urandom);
        loop = 1'b1; loop_mode = 1'b1; vol_rand = 1'b1;
        do_reset();
        enable = 1'b1;
        run_xfer(5 * L, 2000, 60);
        check("loop_not_done", done, 0);
        check("loop_playing", playing, 1);
        loop = 1'b0; loop_mode = 1'b0; vol_rand = 1'b0; vol_shift = 3'd3;

        // Most negative sample shifted by 3; volume change mid-pair ignored.
        rom[0] = 16'h8000;
        do_reset();
        enable = 1'b1;
        begin
            int c;
            c = 0;
            while (o_valid !== 1'b1 && c < 20) begin tick(0); c++; end
        end
        check("vol_left_valid", o_valid, 1);
        check("vol_left_ws", o_ws, 1);
        check("vol_left_data", o_data, 16'hF000);
        tick(100);
        vol_shift = 3'd0;
        check("vol_right_ws", o_ws, 0);
        check("vol_right_data", o_data, 16'hF000);
        tick(100);
        run_done(300, 70);
        check("vol_count", n_xfer, 2 * L);

        // Pause right after a left transfer.
        for (int i = 0; i < L; i++) rom[i] = 16'(i + 1);
        vol_shift = 3'd2;
        do_reset();
        enable = 1'b1;
        run_xfer(5, 100, 100);
        enable = 1'b0;
        saved_addr = int'(rom_addr);
        base_xfer = n_xfer;
        repeat (20) tick(100);
        check("pause_one_right", n_xfer, base_xfer + 1);
        check("pause_idle", o_valid, 0);
        check("pause_addr", rom_addr, saved_addr);
        check("pause_playing", playing, 1);
        enable = 1'b1;
        run_done(300, 80);
        check("pause_count", n_xfer, 2 * L);

        // Reset while a right sample is waiting; replay from sample 1.
        do_reset();
        enable = 1'b1;
        run_xfer(3, 50, 100);
        tick(0);
        check("mid_valid", o_valid, 1);
        check("mid_ws", o_ws, exp_ws);
        do_reset();
        run_done(300, 90);
        check("replay_count", n_xfer, 2 * L);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
